// File: rtl/exa_crosb_demux_if.sv
// Packet stream bus for the crossbar demux: one upstream stream in,
// OUTPUT_NUM per-port streams out.
interface exa_crosb_demux_if #(
   parameter int DATA_WIDTH = 128,
   parameter int OUTPUT_NUM = 16,
   parameter int SEL_WIDTH  = $clog2(OUTPUT_NUM)
);
   logic [DATA_WIDTH-1:0] DATA_i;
   logic                  VALID_i;
   logic                  LAST_i;
   logic                  PRIO_i;
   logic [SEL_WIDTH-1:0]  SEL_i;
   logic                  READY_o;
   logic [DATA_WIDTH-1:0] DATA_o [OUTPUT_NUM];
   logic [OUTPUT_NUM-1:0] VALID_o;
   logic [OUTPUT_NUM-1:0] LAST_o;
   logic [OUTPUT_NUM-1:0] PRIO_o;
   logic [OUTPUT_NUM-1:0] READY_i;

   modport master (
      output DATA_i, VALID_i, LAST_i, PRIO_i, SEL_i, READY_i,
      input  READY_o, DATA_o, VALID_o, LAST_o, PRIO_o
   );
   modport slave (
      input  DATA_i, VALID_i, LAST_i, PRIO_i, SEL_i, READY_i,
      output READY_o, DATA_o, VALID_o, LAST_o, PRIO_o
   );
endinterface

// File: rtl/exa_crosb_demux.sv
// Packet demux: steers each packet to one of OUTPUT_NUM ports through a single
// shared output register; packets to non-existent ports are dropped and counted.
module exa_crosb_demux #(
   parameter int DATA_WIDTH = 128,
   parameter int OUTPUT_NUM = 16,
   parameter int SEL_WIDTH  = $clog2(OUTPUT_NUM)
) (
   input  logic        clk,
   input  logic        resetn,
   exa_crosb_demux_if.slave bus,
   output logic        BUSY_o,
   output logic [15:0] DROP_CNT_o
);
   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] reg_data;
   logic                  reg_last, reg_prio, reg_valid;
   logic [SEL_WIDTH-1:0]  reg_dest, lock_dest, load_dest;
   logic [OUTPUT_NUM-1:0] hit;
   logic                  dest_rdy, accept, sel_ok, load, lock_ld, drop_inc;

   for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_port
      assign hit[k]           = (reg_dest == SEL_WIDTH'(k));
      assign bus.VALID_o[k]   = reg_valid && hit[k];
      assign bus.LAST_o[k]    = hit[k] && reg_last;
      assign bus.PRIO_o[k]    = hit[k] && reg_prio;
      assign bus.DATA_o[k]    = hit[k] ? reg_data : '0;
   end

   // reg_dest only ever holds an in-range port, so the one-hot match is safe
   assign dest_rdy    = |(hit & bus.READY_i);
   assign bus.READY_o = (state == DROP) || !reg_valid || dest_rdy;
   assign accept      = bus.VALID_i && bus.READY_o;
   assign sel_ok      = ({1'b0, bus.SEL_i} < (SEL_WIDTH+1)'(OUTPUT_NUM));
   assign BUSY_o      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      lock_ld   = 1'b0;
      load_dest = lock_dest;
      drop_inc  = 1'b0;
      case (state)
         IDLE: if (accept) begin
            if (sel_ok) begin
               load      = 1'b1;
               lock_ld   = 1'b1;
               load_dest = bus.SEL_i;
               if (!bus.LAST_i) state_nxt = FWD;
            end else begin
               drop_inc = 1'b1;
               if (!bus.LAST_i) state_nxt = DROP;
            end
         end
         FWD: if (accept) begin
            load = 1'b1;
            if (bus.LAST_i) state_nxt = IDLE;
         end
         DROP: if (accept && bus.LAST_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         reg_valid  <= 1'b0;
         reg_dest   <= '0;
         reg_data   <= '0;
         reg_last   <= 1'b0;
         reg_prio   <= 1'b0;
         lock_dest  <= '0;
         DROP_CNT_o <= '0;
      end else begin
         state <= state_nxt;
         // a load in the drain cycle overwrites the entry, keeping reg_valid high
         if (load) begin
            reg_valid <= 1'b1;
            reg_dest  <= load_dest;
            reg_data  <= bus.DATA_i;
            reg_last  <= bus.LAST_i;
            reg_prio  <= bus.PRIO_i;
         end else if (reg_valid && dest_rdy) begin
            reg_valid <= 1'b0;
         end
         if (lock_ld) lock_dest <= load_dest;
         if (drop_inc && DROP_CNT_o != 16'hFFFF) DROP_CNT_o <= DROP_CNT_o + 16'd1;
      end
   end
endmodule

// File: tb/tb_exa_crosb_demux.sv
// Directed bench for exa_crosb_demux with 12 ports (so selects 12..15 are invalid).
module tb_exa_crosb_demux;
   localparam int DW = 32;
   localparam int ON = 12;
   localparam int SW = $clog2(ON);

   logic        clk = 1'b0;
   logic        resetn;
   logic        busy;
   logic [15:0] drop_cnt;
   int          checks = 0;
   int          errors = 0;

   exa_crosb_demux_if #(.DATA_WIDTH(DW), .OUTPUT_NUM(ON), .SEL_WIDTH(SW)) bus ();

   exa_crosb_demux #(.DATA_WIDTH(DW), .OUTPUT_NUM(ON), .SEL_WIDTH(SW)) dut (
      .clk(clk), .resetn(resetn), .bus(bus.slave), .BUSY_o(busy), .DROP_CNT_o(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one beat, expect it accepted, and step past the edge
   task automatic beat(input int sel, input logic [DW-1:0] d, input logic last, input logic prio);
      bus.VALID_i = 1'b1;
      bus.SEL_i   = SW'(sel);
      bus.DATA_i  = d;
      bus.LAST_i  = last;
      bus.PRIO_i  = prio;
      #1;
      chk("ready", 64'(bus.READY_o), 64'd1);
      tick();
   endtask

   task automatic idle();
      bus.VALID_i = 1'b0;
      tick();
   endtask

   initial begin
      resetn = 1'b0;
      bus.VALID_i = 1'b0; bus.LAST_i = 1'b0; bus.PRIO_i = 1'b0;
      bus.SEL_i = '0; bus.DATA_i = '0; bus.READY_i = '1;
      tick(); tick();
      chk("rst_valid", 64'(bus.VALID_o), 64'd0);
      chk("rst_last", 64'(bus.LAST_o), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_data3", 64'(bus.DATA_o[3]), 64'd0);
      resetn = 1'b1;

      // single beat to port 3
      beat(3, 32'hA5, 1'b1, 1'b0);
      chk("t1_valid", 64'(bus.VALID_o), 64'h008);
      chk("t1_data", 64'(bus.DATA_o[3]), 64'hA5);
      chk("t1_last", 64'(bus.LAST_o), 64'h008);
      chk("t1_busy", 64'(busy), 64'd0);
      idle();
      chk("t1_drain", 64'(bus.VALID_o), 64'd0);

      // 4 beats to port 5, later selects ignored
      beat(5, 32'h10, 1'b0, 1'b0);
      chk("t2_v0", 64'(bus.VALID_o), 64'h020);
      chk("t2_d0", 64'(bus.DATA_o[5]), 64'h10);
      chk("t2_l0", 64'(bus.LAST_o), 64'd0);
      chk("t2_b0", 64'(busy), 64'd1);
      for (int i = 1; i < 4; i++) begin
         beat(9, DW'(32'h10 + i), (i == 3), 1'b0);
         chk("t2_v", 64'(bus.VALID_o), 64'h020);
         chk("t2_d", 64'(bus.DATA_o[5]), 64'(32'h10 + i));
         chk("t2_l", 64'(bus.LAST_o), (i == 3) ? 64'h020 : 64'd0);
         chk("t2_b", 64'(busy), (i == 3) ? 64'd0 : 64'd1);
      end
      idle();

      // backpressure on port 5 after beat 1 reaches output
      beat(5, 32'h20, 1'b0, 1'b0);
      beat(5, 32'h21, 1'b0, 1'b1);
      chk("t3_prio", 64'(bus.PRIO_o), 64'h020);
      bus.READY_i[5] = 1'b0;
      bus.DATA_i = 32'h22; bus.PRIO_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_stall_rdy", 64'(bus.READY_o), 64'd0);
         tick();
         chk("t3_hold_d", 64'(bus.DATA_o[5]), 64'h21);
         chk("t3_hold_v", 64'(bus.VALID_o), 64'h020);
         chk("t3_hold_p", 64'(bus.PRIO_o), 64'h020);
      end
      bus.READY_i = '1;
      #1;
      chk("t3_release", 64'(bus.READY_o), 64'd1);
      tick();
      chk("t3_d2", 64'(bus.DATA_o[5]), 64'h22);
      chk("t3_p2", 64'(bus.PRIO_o), 64'd0);
      beat(5, 32'h23, 1'b1, 1'b0);
      chk("t3_d3", 64'(bus.DATA_o[5]), 64'h23);
      chk("t3_l3", 64'(bus.LAST_o), 64'h020);
      idle();

      // back-to-back packets to ports 2 and 7
      beat(2, 32'h30, 1'b0, 1'b0);
      chk("t4_v0", 64'(bus.VALID_o), 64'h004);
      beat(2, 32'h31, 1'b1, 1'b0);
      chk("t4_d1", 64'(bus.DATA_o[2]), 64'h31);
      beat(7, 32'h40, 1'b0, 1'b0);
      chk("t4_v2", 64'(bus.VALID_o), 64'h080);
      chk("t4_d2", 64'(bus.DATA_o[7]), 64'h40);
      chk("t4_z2", 64'(bus.DATA_o[2]), 64'd0);
      beat(7, 32'h41, 1'b1, 1'b0);
      chk("t4_d3", 64'(bus.DATA_o[7]), 64'h41);
      chk("t4_l3", 64'(bus.LAST_o), 64'h080);
      idle();
      chk("t4_drain", 64'(bus.VALID_o), 64'd0);

      // 3-beat packet to non-existent port 13
      beat(13, 32'h50, 1'b0, 1'b0);
      chk("t5_v0", 64'(bus.VALID_o), 64'd0);
      chk("t5_b0", 64'(busy), 64'd1);
      chk("t5_c0", 64'(drop_cnt), 64'd1);
      beat(2, 32'h51, 1'b0, 1'b0);
      chk("t5_v1", 64'(bus.VALID_o), 64'd0);
      beat(2, 32'h52, 1'b1, 1'b0);
      chk("t5_v2", 64'(bus.VALID_o), 64'd0);
      chk("t5_b2", 64'(busy), 64'd0);
      chk("t5_c2", 64'(drop_cnt), 64'd1);
      beat(0, 32'h60, 1'b1, 1'b0);
      chk("t5_next_v", 64'(bus.VALID_o), 64'h001);
      chk("t5_next_d", 64'(bus.DATA_o[0]), 64'h60);
      beat(15, 32'h70, 1'b1, 1'b0);
      chk("t5_drop1_v", 64'(bus.VALID_o), 64'd0);
      chk("t5_drop1_b", 64'(busy), 64'd0);
      chk("t5_drop1_c", 64'(drop_cnt), 64'd2);

      // reset in the middle of a packet to port 4
      beat(4, 32'h80, 1'b0, 1'b0);
      beat(4, 32'h81, 1'b0, 1'b0);
      chk("t6_d1", 64'(bus.DATA_o[4]), 64'h81);
      chk("t6_b1", 64'(busy), 64'd1);
      bus.VALID_i = 1'b0;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("t6_rst_v", 64'(bus.VALID_o), 64'd0);
      chk("t6_rst_b", 64'(busy), 64'd0);
      chk("t6_rst_c", 64'(drop_cnt), 64'd0);
      chk("t6_rst_d", 64'(bus.DATA_o[4]), 64'd0);
      beat(6, 32'h90, 1'b1, 1'b0);
      chk("t6_v", 64'(bus.VALID_o), 64'h040);
      chk("t6_d", 64'(bus.DATA_o[6]), 64'h90);
      chk("t6_b", 64'(busy), 64'd0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
